// File: rtl/lane_merge_buffer_pkg.sv
// Shared definitions for the lane merge buffer: size defaults, lane ids,
// arbiter grant encoding and the occupancy-width helper.
// Optional feature macro: ALMOST_FULL_EN (adds almost-full defaults).
package lane_merge_buffer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
`ifdef ALMOST_FULL_EN
  localparam int unsigned AF_THRESH_DEF = 3;
`endif

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Arbiter decision for one cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_L0   = 2'b01,
    GRANT_L1   = 2'b10
  } grant_e;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lane_merge_buffer_lane_fifo.sv
// lane_fifo: one per-lane buffer with storage, wrapping pointers, occupancy
// counter, registered status flags and a sticky overflow flag.
// A push into a full FIFO is still accepted when a pop happens on the same
// edge. Optional feature macro: ALMOST_FULL_EN (almostFull output).
module lane_fifo
  import lane_merge_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
`ifdef ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = AF_THRESH_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             overflow
`ifdef ALMOST_FULL_EN
  , output logic           almostFull
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = occ_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [OW-1:0] CNT_ONE   = OW'(1);
  localparam logic [OW-1:0] CNT_ZERO  = OW'(0);
  localparam logic [OW-1:0] CNT_FULL  = OW'(DEPTH);
`ifdef ALMOST_FULL_EN
  localparam logic [OW-1:0] CNT_AF    = OW'(AF_THRESH);
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             accept_s;
  logic             pop_s;
`ifdef ALMOST_FULL_EN
  logic             af_q, af_d;
`endif

  // Push/pop qualification, pointer and occupancy next state, flag next state.
  always_comb begin
    pop_s    = pop & ~empty_q;
    accept_s = push & (~full_q | pop_s);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d   = ovf_q | (push & ~accept_s);
    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == CNT_FULL);
`ifdef ALMOST_FULL_EN
    af_d    = (count_d >= CNT_AF);
`endif
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALMOST_FULL_EN
      af_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
`ifdef ALMOST_FULL_EN
      af_q     <= af_d;
`endif
    end
  end

  // Storage array; the slot being read on a full push+pop is overwritten
  // only at the edge, so the popped word is the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept_s) begin
      mem_q[wr_ptr_q] <= data;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign q        = mem_q[rd_ptr_q];
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = ovf_q;
`ifdef ALMOST_FULL_EN
  assign almostFull = af_q;
`endif

endmodule

// File: rtl/lane_merge_buffer.sv
// lane_merge_buffer: buffers two input lanes in lane_fifo instances and
// merges them round-robin into a registered valid/ready output stage.
// Optional feature macro: ALMOST_FULL_EN (almostFull0/1 ports).
module lane_merge_buffer
  import lane_merge_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
`ifdef ALMOST_FULL_EN
  , parameter int unsigned AF_THRESH = AF_THRESH_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic             validIn0,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic             validIn1,
  input  logic             readyIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut,
  output logic             laneOut,
  output logic             empty0,
  output logic             empty1,
  output logic             full0,
  output logic             full1,
  output logic             overflow0,
  output logic             overflow1
`ifdef ALMOST_FULL_EN
  , output logic           almostFull0
  , output logic           almostFull1
`endif
);

  logic [WIDTH-1:0] q0_s, q1_s;
  logic             pop0_s, pop1_s;
  logic             load_s;
  grant_e           grant_s;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             lane_q, lane_d;
  logic             rr_q, rr_d;

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef ALMOST_FULL_EN
    , .AF_THRESH (AF_THRESH)
`endif
  ) u_fifo0 (
    .clk      (clk),
    .reset    (reset),
    .push     (validIn0),
    .data     (dataIn0),
    .pop      (pop0_s),
    .q        (q0_s),
    .empty    (empty0),
    .full     (full0),
    .overflow (overflow0)
`ifdef ALMOST_FULL_EN
    , .almostFull (almostFull0)
`endif
  );

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
`ifdef ALMOST_FULL_EN
    , .AF_THRESH (AF_THRESH)
`endif
  ) u_fifo1 (
    .clk      (clk),
    .reset    (reset),
    .push     (validIn1),
    .data     (dataIn1),
    .pop      (pop1_s),
    .q        (q1_s),
    .empty    (empty1),
    .full     (full1),
    .overflow (overflow1)
`ifdef ALMOST_FULL_EN
    , .almostFull (almostFull1)
`endif
  );

  // Round-robin arbitration over the registered (pre-edge) FIFO state,
  // so a word pushed this cycle is never granted in the same cycle.
  always_comb begin
    grant_s = GRANT_NONE;
    load_s  = ~valid_q | readyIn;
    if (load_s) begin
      if (~empty0 & ~empty1) begin
        grant_s = (rr_q == LANE0) ? GRANT_L0 : GRANT_L1;
      end else if (~empty0) begin
        grant_s = GRANT_L0;
      end else if (~empty1) begin
        grant_s = GRANT_L1;
      end else begin
        grant_s = GRANT_NONE;
      end
    end else begin
      grant_s = GRANT_NONE;
    end
    pop0_s = (grant_s == GRANT_L0);
    pop1_s = (grant_s == GRANT_L1);
  end

  // Output stage next state: load granted word, drain to idle, or hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    lane_d  = lane_q;
    rr_d    = rr_q;
    case (grant_s)
      GRANT_L0: begin
        data_d  = q0_s;
        valid_d = 1'b1;
        lane_d  = LANE0;
        rr_d    = LANE1;
      end
      GRANT_L1: begin
        data_d  = q1_s;
        valid_d = 1'b1;
        lane_d  = LANE1;
        rr_d    = LANE0;
      end
      default: begin
        if (load_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
    endcase
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= LANE0;
      rr_q    <= LANE0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      rr_q    <= rr_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign laneOut  = lane_q;

endmodule

// File: tb/tb_lane_merge_buffer.sv
// Self-checking bench for lane_merge_buffer: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based model. Optional feature macro: ALMOST_FULL_EN.
module tb_lane_merge_buffer;

  localparam int DEPTH = 4;
  localparam int AFT   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataIn0 = 8'h00, dataIn1 = 8'h00;
  logic       validIn0 = 1'b0, validIn1 = 1'b0, readyIn = 1'b0;
  logic [7:0] dataOut;
  logic       validOut, laneOut, empty0, empty1, full0, full1, overflow0, overflow1;
`ifdef ALMOST_FULL_EN
  logic       almostFull0, almostFull1;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  lane_merge_buffer dut (
    .clk(clk), .reset(reset),
    .dataIn0(dataIn0), .validIn0(validIn0),
    .dataIn1(dataIn1), .validIn1(validIn1),
    .readyIn(readyIn),
    .dataOut(dataOut), .validOut(validOut), .laneOut(laneOut),
    .empty0(empty0), .empty1(empty1), .full0(full0), .full1(full1),
    .overflow0(overflow0), .overflow1(overflow1)
`ifdef ALMOST_FULL_EN
    , .almostFull0(almostFull0), .almostFull1(almostFull1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: two queues, a preferred-lane bit and the output word.
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  bit         m_rr, m_v, m_lane, m_ov0, m_ov1, m_init;
  logic [7:0] m_data;

  // Model update on each edge from the sampled inputs, then compare all outputs.
  always @(posedge clk) begin
    if (reset) begin
      mq0.delete(); mq1.delete();
      m_rr = 1'b0; m_v = 1'b0; m_lane = 1'b0; m_data = 8'h00;
      m_ov0 = 1'b0; m_ov1 = 1'b0; m_init = 1'b1;
    end else begin
      int g;
      g = -1;
      if (!m_v || readyIn) begin
        if (mq0.size() > 0 && mq1.size() > 0) g = m_rr ? 1 : 0;
        else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        if (g == 0) m_data = mq0.pop_front();
        if (g == 1) m_data = mq1.pop_front();
        if (g >= 0) begin
          m_v = 1'b1; m_lane = g[0]; m_rr = ~g[0];
        end else begin
          m_v = 1'b0;
        end
      end
      // A slot freed by this edge's pop is available to this edge's push.
      if (validIn0) begin
        if (mq0.size() < DEPTH) mq0.push_back(dataIn0); else m_ov0 = 1'b1;
      end
      if (validIn1) begin
        if (mq1.size() < DEPTH) mq1.push_back(dataIn1); else m_ov1 = 1'b1;
      end
    end
    #1;
    if (m_init) begin
      chk("validOut", {7'd0, validOut}, {7'd0, m_v});
      chk("dataOut", dataOut, m_data);
      chk("laneOut", {7'd0, laneOut}, {7'd0, m_lane});
      chk("empty0", {7'd0, empty0}, {7'd0, mq0.size() == 0});
      chk("empty1", {7'd0, empty1}, {7'd0, mq1.size() == 0});
      chk("full0", {7'd0, full0}, {7'd0, mq0.size() == DEPTH});
      chk("full1", {7'd0, full1}, {7'd0, mq1.size() == DEPTH});
      chk("overflow0", {7'd0, overflow0}, {7'd0, m_ov0});
      chk("overflow1", {7'd0, overflow1}, {7'd0, m_ov1});
`ifdef ALMOST_FULL_EN
      chk("almostFull0", {7'd0, almostFull0}, {7'd0, mq0.size() >= AFT});
      chk("almostFull1", {7'd0, almostFull1}, {7'd0, mq1.size() >= AFT});
`endif
    end
  end

  task automatic step(input bit r, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1, input bit rdy);
    @(negedge clk);
    reset = r; validIn0 = v0; dataIn0 = d0; validIn1 = v1; dataIn1 = d1; readyIn = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    // Reset state.
    do_reset();
    chk("rst_validOut", {7'd0, validOut}, 8'h00);
    chk("rst_dataOut", dataOut, 8'h00);
    chk("rst_empty", {6'd0, empty1, empty0}, 8'h03);
    chk("rst_full_ovf", {4'd0, full1, full0, overflow1, overflow0}, 8'h00);

    // Single word latency.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    chk("lat_e1_valid", {7'd0, validOut}, 8'h00);
    idle(1'b1);
    chk("lat_e2_valid", {7'd0, validOut}, 8'h01);
    chk("lat_e2_data", dataOut, 8'hA5);
    chk("lat_model_data", m_data, 8'hA5);
    chk("lat_e2_lane", {7'd0, laneOut}, 8'h00);
    idle(1'b1);
    chk("lat_e3_valid", {7'd0, validOut}, 8'h00);

    // Both lanes alternate.
    do_reset();
    step(1'b0, 1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h21, 1'b1);
    chk("rr_w0", {laneOut, 7'd0} | {1'b0, dataOut[6:0]}, 8'h10);
    idle(1'b1);
    chk("rr_w1", {laneOut, 7'd0} | {1'b0, dataOut[6:0]}, 8'hA0);
    idle(1'b1);
    chk("rr_w2", {laneOut, 7'd0} | {1'b0, dataOut[6:0]}, 8'h11);
    idle(1'b1);
    chk("rr_w3", {laneOut, 7'd0} | {1'b0, dataOut[6:0]}, 8'hA1);

    // Backpressure, fill and overflow.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    chk("bp_hold_data", dataOut, 8'h01);
    chk("bp_full0", {7'd0, full0}, 8'h01);
    chk("bp_ovf0", {7'd0, overflow0}, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      idle(1'b1);
      chk("bp_drain_data", dataOut, 8'(i));
    end
    idle(1'b1);
    chk("bp_drain_end", {7'd0, validOut}, 8'h00);
    chk("bp_ovf_sticky", {7'd0, overflow0}, 8'h01);

    // Push into full FIFO with simultaneous pop.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    chk("fp_ovf0", {7'd0, overflow0}, 8'h00);
    chk("fp_full0", {7'd0, full0}, 8'h01);
    chk("fp_data", dataOut, 8'h02);

    // Mid-operation reset.
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("mr_valid", {7'd0, validOut}, 8'h00);
    chk("mr_empty", {6'd0, empty1, empty0}, 8'h03);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h5C, 1'b1);
    idle(1'b1);
    chk("mr_lane1", {laneOut, 7'd0} | {1'b0, dataOut[6:0]}, 8'hDC);

`ifdef ALMOST_FULL_EN
    // Almost-full threshold.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h40 + i), 1'b0);
    chk("af_below", {7'd0, almostFull1}, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h43, 1'b0);
    chk("af_rise", {7'd0, almostFull1}, 8'h01);
    idle(1'b1);
    chk("af_fall", {7'd0, almostFull1}, 8'h00);
`endif

    // Randomized traffic with varying backpressure and occasional resets.
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      int rdy_pct, v_pct;
      rdy_pct = $urandom_range(10, 100);
      v_pct   = $urandom_range(10, 90);
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < v_pct, 8'($urandom),
             $urandom_range(0, 99) < v_pct, 8'($urandom),
             $urandom_range(0, 99) < rdy_pct);
      end
    end
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
